mini_alu_divider: RTL and testbench

Sequential 6-bit two's-complement divider for the Mini ALU, the inverse arithmetic path to the 6-bit ripple adder/subtractor. It computes quotient and remainder of `x / y` by restoring division, one quotient bit per clock. Results use C semantics: truncation toward zero, and the remainder takes the sign of the dividend. It sits beside the adder behind the ALU operation select, with a start/done handshake.

---
 rtl/mini_alu_divider.sv | 134 +++++++++++++
 tb/tb_mini_alu_divider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_divider.sv
// 6-bit restoring divider, one quotient bit per clock, start/done handshake.
// Define MINI_ALU_SIGNED_DIV_EN for signed (C-style) division; unsigned otherwise.
module mini_alu_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic       busy,
  output logic       done,
  output logic [5:0] quotient,
  output logic [5:0] remainder,
  output logic       div_by_zero,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    ZERO
  } state_t;

  state_t     state;
  logic [5:0] dvd;
  logic [5:0] dvs;
  logic [5:0] part;
  logic [5:0] q;
  logic [5:0] raw_x;
  logic [2:0] cnt;

  logic [5:0] mag_x;
  logic [5:0] mag_y;
  logic [6:0] shifted;
  logic       take;
  logic [5:0] fix_q;
  logic [5:0] fix_r;

`ifdef MINI_ALU_SIGNED_DIV_EN
  logic sign_q;
  logic sign_r;
  logic ovf;

  assign mag_x = x[5] ? ~x + 6'd1 : x;
  assign mag_y = y[5] ? ~y + 6'd1 : y;
  assign fix_q = sign_q ? ~q + 6'd1 : q;
  assign fix_r = sign_r ? ~part + 6'd1 : part;
`else
  assign mag_x = x;
  assign mag_y = y;
  assign fix_q = q;
  assign fix_r = part;
`endif

  // Unsigned remainders reach 62, so the shifted partial needs a 7th bit.
  assign shifted = {part, dvd[5]};
  assign take    = shifted >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      part        <= '0;
      q           <= '0;
      raw_x       <= '0;
      cnt         <= '0;
`ifdef MINI_ALU_SIGNED_DIV_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd   <= mag_x;
            dvs   <= mag_y;
            raw_x <= x;
            part  <= '0;
            q     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef MINI_ALU_SIGNED_DIV_EN
            sign_q <= x[5] ^ y[5];
            sign_r <= x[5];
            ovf    <= (x == 6'h20) && (y == 6'h3f);
`endif
            state <= (y == 6'd0) ? ZERO : DIV;
          end
        end
        DIV: begin
          part <= take ? 6'(shifted - {1'b0, dvs})
                       : shifted[5:0];
          q    <= {q[4:0], take};
          dvd  <= {dvd[4:0], 1'b0};
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd5) state <= FIX;
        end
        FIX: begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= 1'b0;
`ifdef MINI_ALU_SIGNED_DIV_EN
          overflow    <= ovf;
`else
          overflow    <= 1'b0;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ZERO: begin
          quotient    <= 6'h3f;
          remainder   <= raw_x;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_divider.sv
// Randomized self-checking bench for mini_alu_divider against an
// arithmetic reference model; follows MINI_ALU_SIGNED_DIV_EN like the RTL.
module tb_mini_alu_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] x = '0;
  logic [5:0] y = '0;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int checks = 0;
  int passes = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mini_alu_divider dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x(x),
    .y(y),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  // Reference: what the divide must return, straight from integer arithmetic.
  function automatic void ref_div(
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] rq,
    output logic [5:0] rr,
    output logic       rz,
    output logic       ro
  );
    int sa;
    int sb;
`ifdef MINI_ALU_SIGNED_DIV_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    rz = 1'b0;
    ro = 1'b0;
    if (sb == 0) begin
      rq = 6'h3f;
      rr = a;
      rz = 1'b1;
    end else begin
      rq = 6'(sa / sb);
      rr = 6'(sa % sb);
      ro = (sa == -32) && (sb == -1);
    end
  endfunction

  // Model state: cycles until the pending result appears, and held outputs.
  int         remaining = 0;
  logic       m_done = 1'b0;
  logic [5:0] m_q = '0, m_r = '0;
  logic       m_z = 1'b0, m_o = 1'b0;
  logic [5:0] p_q, p_r;
  logic       p_z, p_o;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      remaining = 0;
      m_q = '0;
      m_r = '0;
      m_z = 1'b0;
      m_o = 1'b0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        m_done = 1'b1;
        m_q = p_q;
        m_r = p_r;
        m_z = p_z;
        m_o = p_o;
      end
    end else if (start) begin
      ref_div(x, y, p_q, p_r, p_z, p_o);
      remaining = (y == 6'd0) ? 1 : 7;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [15:0] got;
      logic [15:0] exp;
      got = {busy, done, quotient, remainder, div_by_zero, overflow};
      exp = {remaining > 0, m_done, m_q, m_r, m_z, m_o};
      checks++;
      if (got === exp) passes++;
      else
        $display("FAIL cycle t=%0t: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected busy=%b done=%b q=%h r=%h dz=%b ov=%b",
                 $time, got[15], got[14], got[13:8], got[7:2], got[1], got[0],
                 exp[15], exp[14], exp[13:8], exp[7:2], exp[1], exp[0]);
    end
  end

  task automatic lit(input string tag, input logic [5:0] eq,
                     input logic [5:0] er, input logic ez,
                     input logic eo);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} === {eq, er, ez, eo})
      passes++;
    else
      $display("FAIL %s dut: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
               tag, quotient, remainder, div_by_zero, overflow, eq, er, ez, eo);
    checks++;
    if ({m_q, m_r, m_z, m_o} === {eq, er, ez, eo})
      passes++;
    else
      $display("FAIL %s model: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
               tag, m_q, m_r, m_z, m_o, eq, er, ez, eo);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    checks++;
    if (done) passes++;
    else $display("FAIL %s timeout: got done=%b, expected done=1 within 20 cycles", tag, done);
  endtask

  task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                        input string tag);
    start = 1'b1;
    x = a;
    y = b;
    tick();
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    checking = 1'b1;
    tick();
    reset = 1'b0;
    lit("reset", 6'd0, 6'd0, 1'b0, 1'b0);

    run_op(6'd13, 6'd4, "13/4");
    lit("13/4", 6'd3, 6'd1, 1'b0, 1'b0);
    run_op(6'd5, 6'd0, "5/0");
    lit("5/0", 6'h3f, 6'd5, 1'b1, 1'b0);
`ifdef MINI_ALU_SIGNED_DIV_EN
    run_op(6'b110011, 6'd4, "-13/4");
    lit("-13/4", 6'b111101, 6'b111111, 1'b0, 1'b0);
    run_op(6'd13, 6'b111100, "13/-4");
    lit("13/-4", 6'b111101, 6'b000001, 1'b0, 1'b0);
    run_op(6'b100000, 6'b111111, "-32/-1");
    lit("-32/-1", 6'b100000, 6'd0, 1'b0, 1'b1);
`else
    run_op(6'd52, 6'd5, "52/5");
    lit("52/5", 6'd10, 6'd2, 1'b0, 1'b0);
    run_op(6'd63, 6'd1, "63/1");
    lit("63/1", 6'd63, 6'd0, 1'b0, 1'b0);
`endif

    // Start ignored while busy, then start accepted in the done cycle.
    start = 1'b1; x = 6'd20; y = 6'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; x = 6'd7; y = 6'd7;
    tick();
    start = 1'b0;
    wait_done("20/3");
    lit("20/3", 6'd6, 6'd2, 1'b0, 1'b0);
    start = 1'b1; x = 6'd7; y = 6'd7;
    tick();
    start = 1'b0;
    wait_done("7/7");
    lit("7/7", 6'd1, 6'd0, 1'b0, 1'b0);

    // Abort mid-division, then reset colliding with start.
    start = 1'b1; x = 6'd30; y = 6'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lit("abort", 6'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++;
    if (!busy) passes++;
    else $display("FAIL reset+start: got busy=%b, expected busy=0", busy);
    run_op(6'd30, 6'd7, "30/7");
    lit("30/7", 6'd4, 6'd2, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      x = 6'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        x = 6'h20;
        y = 6'h3f;
      end
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (10) tick();
    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
